// File: rtl/chess_clock_pkg.sv
// Shared constants for the chess-clock setup controller: widths, adjust steps,
// FSM state encodings and the edited-field encoding.
package chess_clock_pkg;

    localparam int TIME_W_DEF       = 13;
    localparam int INC_W_DEF        = 6;

    localparam int TIME_STEP_FINE   = 1;
    localparam int TIME_STEP_COARSE = 60;
    localparam int INC_STEP_FINE    = 1;
    localparam int INC_STEP_COARSE  = 10;

    localparam int ST_W = 3;
    localparam logic [2:0] ST_LOCKED   = 3'd0;
    localparam logic [2:0] ST_COMMIT   = 3'd1;
    localparam logic [2:0] ST_READY    = 3'd2;
    localparam logic [2:0] ST_EDIT_A   = 3'd3;
    localparam logic [2:0] ST_EDIT_B   = 3'd4;
    localparam logic [2:0] ST_EDIT_INC = 3'd5;

    typedef enum logic [1:0] {
        FIELD_NONE   = 2'd0,
        FIELD_TIME_A = 2'd1,
        FIELD_TIME_B = 2'd2,
        FIELD_INC    = 2'd3
    } edit_field_e;

    function automatic logic is_edit_state(input logic [2:0] st);
        return (st == ST_EDIT_A) || (st == ST_EDIT_B) || (st == ST_EDIT_INC);
    endfunction

endpackage

// File: rtl/chess_clock_setup_if.sv
// Button inputs and configuration outputs of the setup controller.
// Inputs are sampled on the rising clock edge; outputs are valid the whole cycle.
interface chess_clock_setup_if import chess_clock_pkg::*; #(
    parameter int TIME_W = TIME_W_DEF,
    parameter int INC_W  = INC_W_DEF
);
    logic              i_idle;
    logic              i_mode;
    logic              i_up;
    logic              i_down;
    logic              i_coarse;
    logic              i_confirm;
    logic              i_cancel;
    logic [TIME_W-1:0] o_time_a;
    logic [TIME_W-1:0] o_time_b;
    logic [INC_W-1:0]  o_increment;
    logic              o_load;
    logic [1:0]        o_edit_field;
    logic [TIME_W-1:0] o_edit_value;
    logic              o_setup_active;
    logic [ST_W-1:0]   o_dbg_state;

    modport master (
        output i_idle, i_mode, i_up, i_down, i_coarse, i_confirm, i_cancel,
        input  o_time_a, o_time_b, o_increment, o_load, o_edit_field,
               o_edit_value, o_setup_active, o_dbg_state
    );

    modport slave (
        input  i_idle, i_mode, i_up, i_down, i_coarse, i_confirm, i_cancel,
        output o_time_a, o_time_b, o_increment, o_load, o_edit_field,
               o_edit_value, o_setup_active, o_dbg_state
    );
endinterface

// File: rtl/chess_clock_sat_adj.sv
// Combinational saturating up/down adjuster; up and down together leave the value as is.
module chess_clock_sat_adj #(
    parameter int W           = 13,
    parameter int MIN_V       = 1,
    parameter int MAX_V       = 5999,
    parameter int STEP_FINE   = 1,
    parameter int STEP_COARSE = 60
) (
    input  logic [W-1:0] i_value,
    input  logic         i_up,
    input  logic         i_down,
    input  logic         i_coarse,
    output logic [W-1:0] o_value
);
    logic [W:0] w_step;
    logic [W:0] w_sum;
    logic [W:0] w_floor;
    logic [W:0] w_diff;

    // One extra bit so the sum never wraps before the clamp compares it.
    always_comb begin
        w_step  = i_coarse ? (W+1)'(STEP_COARSE) : (W+1)'(STEP_FINE);
        w_sum   = {1'b0, i_value} + w_step;
        w_floor = w_step + (W+1)'(MIN_V);
        w_diff  = {1'b0, i_value} - w_step;
        o_value = i_value;
        if (i_up && !i_down) begin
            o_value = (w_sum > (W+1)'(MAX_V)) ? W'(MAX_V) : w_sum[W-1:0];
        end else if (i_down && !i_up) begin
            o_value = ({1'b0, i_value} < w_floor) ? W'(MIN_V) : w_diff[W-1:0];
        end
    end
endmodule

// File: rtl/chess_clock_setup.sv
// Setup menu for the chess clock: edits shadow copies of both player times and the
// increment while the game is idle, commits them with a one-cycle load strobe.
module chess_clock_setup import chess_clock_pkg::*; #(
    parameter int TIME_W       = TIME_W_DEF,
    parameter int MIN_TIME     = 1,
    parameter int MAX_TIME     = 5999,
    parameter int DEFAULT_TIME = 300,
    parameter int INC_W        = INC_W_DEF,
    parameter int MAX_INC      = 59,
    parameter int DEFAULT_INC  = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    chess_clock_setup_if.slave  io_setup
);
    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [TIME_W-1:0] r_time_a, r_time_b, r_sh_a, r_sh_b;
    logic [INC_W-1:0]  r_inc, r_sh_inc;
    logic [TIME_W-1:0] w_adj_a, w_adj_b;
    logic [INC_W-1:0]  w_adj_inc;
    logic              w_in_edit;
    logic              w_discard;
    logic              w_hold;

    chess_clock_sat_adj #(.W(TIME_W), .MIN_V(MIN_TIME), .MAX_V(MAX_TIME),
        .STEP_FINE(TIME_STEP_FINE), .STEP_COARSE(TIME_STEP_COARSE)) u_adj_a (
        .i_value(r_sh_a), .i_up(io_setup.i_up), .i_down(io_setup.i_down),
        .i_coarse(io_setup.i_coarse), .o_value(w_adj_a));

    chess_clock_sat_adj #(.W(TIME_W), .MIN_V(MIN_TIME), .MAX_V(MAX_TIME),
        .STEP_FINE(TIME_STEP_FINE), .STEP_COARSE(TIME_STEP_COARSE)) u_adj_b (
        .i_value(r_sh_b), .i_up(io_setup.i_up), .i_down(io_setup.i_down),
        .i_coarse(io_setup.i_coarse), .o_value(w_adj_b));

    chess_clock_sat_adj #(.W(INC_W), .MIN_V(0), .MAX_V(MAX_INC),
        .STEP_FINE(INC_STEP_FINE), .STEP_COARSE(INC_STEP_COARSE)) u_adj_inc (
        .i_value(r_sh_inc), .i_up(io_setup.i_up), .i_down(io_setup.i_down),
        .i_coarse(io_setup.i_coarse), .o_value(w_adj_inc));

    assign w_in_edit = is_edit_state(r_state);
    assign w_discard = !io_setup.i_idle || io_setup.i_cancel;
    assign w_hold    = io_setup.i_confirm || io_setup.i_mode;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOCKED: if (io_setup.i_idle) w_next = ST_COMMIT;
            ST_COMMIT: w_next = io_setup.i_idle ? ST_READY : ST_LOCKED;
            ST_READY: begin
                if (!io_setup.i_idle)    w_next = ST_LOCKED;
                else if (io_setup.i_mode) w_next = ST_EDIT_A;
            end
            ST_EDIT_A, ST_EDIT_B, ST_EDIT_INC: begin
                if (!io_setup.i_idle)        w_next = ST_LOCKED;
                else if (io_setup.i_cancel)  w_next = ST_READY;
                else if (io_setup.i_confirm) w_next = ST_COMMIT;
                else if (io_setup.i_mode) begin
                    case (r_state)
                        ST_EDIT_A: w_next = ST_EDIT_B;
                        ST_EDIT_B: w_next = ST_EDIT_INC;
                        default:   w_next = ST_EDIT_A;
                    endcase
                end
            end
            default: w_next = ST_LOCKED;
        endcase
    end

    // Outside an active edit the shadows track the committed values, so a discard
    // is simply a reload and entering EDIT_A always starts from committed values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_LOCKED;
            r_time_a <= TIME_W'(DEFAULT_TIME);
            r_time_b <= TIME_W'(DEFAULT_TIME);
            r_inc    <= INC_W'(DEFAULT_INC);
            r_sh_a   <= TIME_W'(DEFAULT_TIME);
            r_sh_b   <= TIME_W'(DEFAULT_TIME);
            r_sh_inc <= INC_W'(DEFAULT_INC);
        end else begin
            r_state <= w_next;
            if (w_next == ST_COMMIT) begin
                r_time_a <= r_sh_a;
                r_time_b <= r_sh_b;
                r_inc    <= r_sh_inc;
            end
            if (w_in_edit && !w_discard) begin
                if (!w_hold) begin
                    case (r_state)
                        ST_EDIT_A: r_sh_a   <= w_adj_a;
                        ST_EDIT_B: r_sh_b   <= w_adj_b;
                        default:   r_sh_inc <= w_adj_inc;
                    endcase
                end
            end else begin
                r_sh_a   <= r_time_a;
                r_sh_b   <= r_time_b;
                r_sh_inc <= r_inc;
            end
        end
    end

    always_comb begin
        io_setup.o_edit_field = FIELD_NONE;
        io_setup.o_edit_value = '0;
        case (r_state)
            ST_EDIT_A: begin
                io_setup.o_edit_field = FIELD_TIME_A;
                io_setup.o_edit_value = r_sh_a;
            end
            ST_EDIT_B: begin
                io_setup.o_edit_field = FIELD_TIME_B;
                io_setup.o_edit_value = r_sh_b;
            end
            ST_EDIT_INC: begin
                io_setup.o_edit_field = FIELD_INC;
                io_setup.o_edit_value = TIME_W'(r_sh_inc);
            end
            default: ;
        endcase
    end

    assign io_setup.o_time_a       = r_time_a;
    assign io_setup.o_time_b       = r_time_b;
    assign io_setup.o_increment    = r_inc;
    assign io_setup.o_load         = (r_state == ST_COMMIT);
    assign io_setup.o_setup_active = w_in_edit;
    assign io_setup.o_dbg_state    = r_state;
endmodule

// File: tb/tb_chess_clock_setup.sv
// Directed bench for chess_clock_setup: a driver issues button sequences and pushes
// expected snapshots; a monitor pops them on probe strobes and on every load pulse.
module tb_chess_clock_setup;
    import chess_clock_pkg::*;

    localparam int SW = 52;
    localparam int LW = 32;
    localparam logic [4:0] B_MODE = 5'b00001;
    localparam logic [4:0] B_UP   = 5'b00010;
    localparam logic [4:0] B_DOWN = 5'b00100;
    localparam logic [4:0] B_CONF = 5'b01000;
    localparam logic [4:0] B_CANC = 5'b10000;

    logic clk;
    logic rst_n;
    logic probe;
    int   checks;
    int   errors;

    logic [SW-1:0] exp_q[$];
    string         tag_q[$];
    logic [LW-1:0] load_q[$];

    chess_clock_setup_if bus ();

    chess_clock_setup dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_setup(bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [SW-1:0] pack_status(input logic [2:0] st, input logic [1:0] fld,
        input logic [12:0] val, input logic act, input logic ld, input logic [12:0] ta,
        input logic [12:0] tb, input logic [5:0] inc);
        return {st, fld, val, act, ld, ta, tb, inc};
    endfunction

    // Driver tasks
    task automatic press(input logic [4:0] b);
        bus.i_mode    = b[0];
        bus.i_up      = b[1];
        bus.i_down    = b[2];
        bus.i_confirm = b[3];
        bus.i_cancel  = b[4];
        @(negedge clk);
        bus.i_mode    = 1'b0;
        bus.i_up      = 1'b0;
        bus.i_down    = 1'b0;
        bus.i_confirm = 1'b0;
        bus.i_cancel  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [2:0] st, input logic [1:0] fld,
        input logic [12:0] val, input logic act, input logic ld, input logic [12:0] ta,
        input logic [12:0] tb, input logic [5:0] inc);
        exp_q.push_back(pack_status(st, fld, val, act, ld, ta, tb, inc));
        tag_q.push_back(tag);
        probe = 1'b1;
        @(negedge clk);
        probe = 1'b0;
    endtask

    task automatic expect_load(input logic [12:0] ta, input logic [12:0] tb, input logic [5:0] inc);
        load_q.push_back({ta, tb, inc});
    endtask

    // Monitor / scoreboard
    initial begin
        logic [SW-1:0] act_s, exp_s;
        logic [LW-1:0] act_l, exp_l;
        string tag;
        forever begin
            @(negedge clk);
            #2;
            if (bus.o_load === 1'b1) begin
                act_l = {bus.o_time_a, bus.o_time_b, bus.o_increment};
                checks++;
                if (load_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_load got=%h (none expected) t=%0t", act_l, $time);
                end else begin
                    exp_l = load_q.pop_front();
                    if (act_l !== exp_l) begin
                        errors++;
                        $display("FAIL load_values got=%h exp=%h t=%0t", act_l, exp_l, $time);
                    end
                end
            end
            if (probe) begin
                act_s = pack_status(bus.o_dbg_state, bus.o_edit_field, bus.o_edit_value,
                    bus.o_setup_active, bus.o_load, bus.o_time_a, bus.o_time_b, bus.o_increment);
                exp_s = exp_q.pop_front();
                tag   = tag_q.pop_front();
                checks++;
                if (act_s !== exp_s) begin
                    errors++;
                    $display("FAIL %s got=%h exp=%h t=%0t", tag, act_s, exp_s, $time);
                end
            end
        end
    end

    // Stimulus
    initial begin
        checks = 0;
        errors = 0;
        probe  = 1'b0;
        rst_n  = 1'b0;
        bus.i_idle    = 1'b1;
        bus.i_coarse  = 1'b0;
        bus.i_mode    = 1'b0;
        bus.i_up      = 1'b0;
        bus.i_down    = 1'b0;
        bus.i_confirm = 1'b0;
        bus.i_cancel  = 1'b0;
        repeat (2) @(negedge clk);
        check("in_reset", ST_LOCKED, 0, 0, 0, 0, 300, 300, 0);

        expect_load(300, 300, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_commit", ST_COMMIT, 0, 0, 0, 1, 300, 300, 0);
        check("first_ready", ST_READY, 0, 0, 0, 0, 300, 300, 0);

        press(B_MODE);
        check("enter_a", ST_EDIT_A, 1, 300, 1, 0, 300, 300, 0);
        repeat (3) press(B_UP);
        check("a_up3", ST_EDIT_A, 1, 303, 1, 0, 300, 300, 0);
        press(B_MODE);
        check("enter_b", ST_EDIT_B, 2, 300, 1, 0, 300, 300, 0);
        bus.i_coarse = 1'b1;
        repeat (2) press(B_DOWN);
        bus.i_coarse = 1'b0;
        check("b_coarse_down2", ST_EDIT_B, 2, 180, 1, 0, 300, 300, 0);
        press(B_MODE);
        check("enter_inc", ST_EDIT_INC, 3, 0, 1, 0, 300, 300, 0);
        repeat (5) press(B_UP);
        check("inc_up5", ST_EDIT_INC, 3, 5, 1, 0, 300, 300, 0);
        expect_load(303, 180, 5);
        press(B_CONF);
        check("confirm_commit", ST_COMMIT, 0, 0, 0, 1, 303, 180, 5);
        check("confirm_ready", ST_READY, 0, 0, 0, 0, 303, 180, 5);

        press(B_MODE);
        bus.i_coarse = 1'b1;
        repeat (100) press(B_UP);
        check("a_sat_max", ST_EDIT_A, 1, 5999, 1, 0, 303, 180, 5);
        press(B_DOWN);
        bus.i_coarse = 1'b0;
        press(B_UP);
        check("a_5940", ST_EDIT_A, 1, 5940, 1, 0, 303, 180, 5);
        bus.i_coarse = 1'b1;
        repeat (2) press(B_UP);
        check("a_5940_up2", ST_EDIT_A, 1, 5999, 1, 0, 303, 180, 5);
        repeat (100) press(B_DOWN);
        check("a_sat_min", ST_EDIT_A, 1, 1, 1, 0, 303, 180, 5);
        bus.i_coarse = 1'b0;
        press(B_DOWN);
        check("a_min_fine_down", ST_EDIT_A, 1, 1, 1, 0, 303, 180, 5);
        press(B_MODE);
        press(B_MODE);
        repeat (6) press(B_DOWN);
        check("inc_sat_zero", ST_EDIT_INC, 3, 0, 1, 0, 303, 180, 5);
        bus.i_coarse = 1'b1;
        repeat (5) press(B_UP);
        bus.i_coarse = 1'b0;
        repeat (5) press(B_UP);
        check("inc_55", ST_EDIT_INC, 3, 55, 1, 0, 303, 180, 5);
        bus.i_coarse = 1'b1;
        press(B_UP);
        bus.i_coarse = 1'b0;
        check("inc_sat_max", ST_EDIT_INC, 3, 59, 1, 0, 303, 180, 5);
        press(B_CANC);
        check("cancel_ready", ST_READY, 0, 0, 0, 0, 303, 180, 5);

        press(B_MODE);
        bus.i_coarse = 1'b1;
        press(B_UP);
        bus.i_coarse = 1'b0;
        check("a_363", ST_EDIT_A, 1, 363, 1, 0, 303, 180, 5);
        bus.i_idle = 1'b0;
        @(negedge clk);
        check("abort_locked", ST_LOCKED, 0, 0, 0, 0, 303, 180, 5);
        check("locked_hold", ST_LOCKED, 0, 0, 0, 0, 303, 180, 5);
        expect_load(303, 180, 5);
        bus.i_idle = 1'b1;
        @(negedge clk);
        check("restart_commit", ST_COMMIT, 0, 0, 0, 1, 303, 180, 5);
        check("restart_ready", ST_READY, 0, 0, 0, 0, 303, 180, 5);

        press(B_MODE);
        press(B_MODE);
        check("b_entry", ST_EDIT_B, 2, 180, 1, 0, 303, 180, 5);
        press(B_UP | B_DOWN);
        check("b_up_down_same", ST_EDIT_B, 2, 180, 1, 0, 303, 180, 5);
        press(B_UP);
        check("b_181", ST_EDIT_B, 2, 181, 1, 0, 303, 180, 5);
        press(B_CANC);
        check("b_cancel", ST_READY, 0, 0, 0, 0, 303, 180, 5);
        press(B_MODE | B_CONF);
        check("ready_mode_wins", ST_EDIT_A, 1, 303, 1, 0, 303, 180, 5);
        press(B_MODE);
        check("b_discarded", ST_EDIT_B, 2, 180, 1, 0, 303, 180, 5);

        press(B_MODE);
        press(B_UP);
        check("inc_6", ST_EDIT_INC, 3, 6, 1, 0, 303, 180, 5);
        rst_n = 1'b0;
        check("async_reset", ST_LOCKED, 0, 0, 0, 0, 300, 300, 0);
        repeat (3) @(negedge clk);
        bus.i_idle = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_locked", ST_LOCKED, 0, 0, 0, 0, 300, 300, 0);
        repeat (3) @(negedge clk);

        checks++;
        if (load_q.size() != 0) begin
            errors++;
            $display("FAIL missing_load got=%0d pending exp=0", load_q.size());
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL unchecked_status got=%0d pending exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
